// File: rtl/dmem_responder.sv
// Latency-configurable data-memory responder for the MEM-stage load/store port.
// Optional statistics counters are built when DMEM_STATS_EN is defined.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count,
   output logic [31:0] err_count
`endif
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_rsp_valid;
   logic [63:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic [63:0] r_mem [DEPTH_WORDS];

   logic        w_accept;
   logic        w_err;
   logic [60:0] w_index;
   logic [AW-1:0] w_word;
   logic [63:0] w_rd_word;

   function automatic logic [63:0] merge_bytes(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  strb);
      logic [63:0] result;
      result = old_word;
      for (int i = 0; i < 8; i++) begin
         if (strb[i]) begin
            result[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            result[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return result;
   endfunction

   // Request decode; req_ready must drop in the same cycle rst is high.
   always_comb begin
      w_index   = req_addr[63:3];
      w_word    = w_index[AW-1:0];
      w_err     = (req_addr[2:0] != 3'd0) || (w_index >= 61'(DEPTH_WORDS));
      req_ready = (r_state == ST_IDLE) && !rst;
      w_accept  = req_valid && req_ready;
      w_rd_word = r_mem[w_word];
   end

   // Storage array: byte-masked writes at the accept edge, never cleared.
   always_ff @(posedge clk) begin
      if (w_accept && req_write && !w_err) begin
         r_mem[w_word] <= merge_bytes(r_mem[w_word], req_wdata, req_wstrb);
      end
   end

   // Transaction FSM with registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 64'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_rsp_err   <= w_err;
                  r_rsp_rdata <= (req_write || w_err) ? 64'd0 : w_rd_word;
                  if (LATENCY <= 1) begin
                     r_state     <= ST_RESP;
                     r_rsp_valid <= 1'b1;
                  end else begin
                     r_state <= ST_WAIT;
                     r_cnt   <= CNT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

`ifdef DMEM_STATS_EN
   logic [31:0] r_rd_count;
   logic [31:0] r_wr_count;
   logic [31:0] r_err_count;

   // Access statistics, counted at the accept edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_count  <= 32'd0;
         r_wr_count  <= 32'd0;
         r_err_count <= 32'd0;
      end else if (w_accept) begin
         if (w_err) begin
            r_err_count <= r_err_count + 32'd1;
         end else if (req_write) begin
            r_wr_count <= r_wr_count + 32'd1;
         end else begin
            r_rd_count <= r_rd_count + 32'd1;
         end
      end
   end

   assign rd_count  = r_rd_count;
   assign wr_count  = r_wr_count;
   assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed test-plan steps followed by
// randomized traffic against a word-array reference model.
module tb_dmem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
`ifdef DMEM_STATS_EN
   logic [31:0] rd_count;
   logic [31:0] wr_count;
   logic [31:0] err_count;
`endif

   int errors = 0;
   int checks = 0;
   int m_rd   = 0;
   int m_wr   = 0;
   int m_err  = 0;
   logic [63:0] model_mem [16];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_STATS_EN
      , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive ignored request traffic while the responder is busy.
   task automatic distract();
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'b1;
      req_addr  = 64'($urandom_range(0, 15)) * 64'd8;
      req_wdata = {$urandom, $urandom};
      req_wstrb = 8'hFF;
   endtask

   // One full transaction, entered and left at a negedge in IDLE.
   task automatic txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] strb, input int hold, output logic [63:0] obs);
      logic [63:0] word;
      logic        err;
      logic [63:0] exp_d;
      word  = addr / 64'd8;
      err   = ((addr % 64'd8) != 64'd0) || (word >= 64'(DEPTH));
      exp_d = 64'd0;
      if (!err && !wr) exp_d = model_mem[word[3:0]];
      if (!err && wr) begin
         for (int b = 0; b < 8; b++)
            if (strb[b]) model_mem[word[3:0]][8*b +: 8] = wdata[8*b +: 8];
      end
      if (err) m_err++;
      else if (wr) m_wr++;
      else m_rd++;

      chk("ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      rsp_ready = (hold == 0);
      @(posedge clk);
      for (int c = 1; c <= LAT; c++) begin
         @(negedge clk);
         distract();
         chk("latency_valid", 64'(rsp_valid), (c == LAT) ? 64'd1 : 64'd0);
         chk("busy_ready", 64'(req_ready), 64'd0);
      end
      obs = rsp_rdata;
      chk("rsp_rdata", rsp_rdata, exp_d);
      chk("rsp_err", 64'(rsp_err), 64'(err));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         distract();
         chk("hold_valid", 64'(rsp_valid), 64'd1);
         chk("hold_rdata", rsp_rdata, exp_d);
         chk("hold_err", 64'(rsp_err), 64'(err));
         chk("hold_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("post_valid", 64'(rsp_valid), 64'd0);
      chk("post_ready", 64'(req_ready), 64'd1);
   endtask

   task automatic check_stats(input string tag);
`ifdef DMEM_STATS_EN
      chk({tag, "_rd"}, 64'(rd_count), 64'(m_rd));
      chk({tag, "_wr"}, 64'(wr_count), 64'(m_wr));
      chk({tag, "_err"}, 64'(err_count), 64'(m_err));
`else
      chk({tag, "_nostats_valid"}, 64'(rsp_valid), 64'd0);
`endif
   endtask

   task automatic do_reset(input int cycles);
      rst       = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      m_rd = 0; m_wr = 0; m_err = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk("rst_ready", 64'(req_ready), 64'd0);
         chk("rst_valid", 64'(rsp_valid), 64'd0);
      end
      rst = 1'b0;
      #1;
      chk("rst_release_ready", 64'(req_ready), 64'd1);
   endtask

   logic [63:0] got;
   logic [63:0] r_addr;
   int          sel;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0;
      req_wdata = 64'd0; req_wstrb = 8'd0; rsp_ready = 1'b0;

      // Reset values.
      @(negedge clk);
      @(negedge clk);
      chk("reset_rdata", rsp_rdata, 64'd0);
      chk("reset_err", 64'(rsp_err), 64'd0);
      check_stats("reset");
      do_reset(2);

      // Initialise the model pool.
      for (int w = 0; w < 16; w++)
         txn(1'b1, 64'(w) * 64'd8, {$urandom, $urandom}, 8'hFF, 0, got);

      // Store then load, then partial store.
      txn(1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 0, got);
      chk("store_rdata_zero", got, 64'd0);
      txn(1'b0, 64'h10, 64'd0, 8'h00, 0, got);
      chk("load_full", got, 64'h1122334455667788);
      txn(1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, got);
      txn(1'b0, 64'h10, 64'd0, 8'h00, 0, got);
      chk("load_partial", got, 64'h11223344AAAAAAAA);

      // Errors: misaligned load, out-of-range store, word 0 untouched.
      txn(1'b0, 64'h13, 64'd0, 8'h00, 0, got);
      txn(1'b1, 64'(DEPTH) * 64'd8, 64'hDEADBEEFDEADBEEF, 8'hFF, 0, got);
      txn(1'b0, 64'h0, 64'd0, 8'h00, 0, got);

      // Zero-strobe store, back-pressured load.
      txn(1'b1, 64'h18, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1, got);
      txn(1'b0, 64'h18, 64'd0, 8'h00, 5, got);

      // Reset during WAIT of a load: no response may appear.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h20; rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      do_reset(2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
      end

      // Reset during WAIT of a store: the store stays committed.
      model_mem[5] = 64'h0F0E0D0C0B0A0908;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h28;
      req_wdata = 64'h0F0E0D0C0B0A0908; req_wstrb = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      do_reset(1);
      txn(1'b0, 64'h28, 64'd0, 8'h00, 0, got);
      chk("store_survives_rst", got, 64'h0F0E0D0C0B0A0908);

      // Statistics: 3 loads, 2 stores, 1 misaligned after a fresh reset.
      do_reset(1);
      txn(1'b0, 64'h00, 64'd0, 8'h00, 0, got);
      txn(1'b0, 64'h08, 64'd0, 8'h00, 0, got);
      txn(1'b0, 64'h30, 64'd0, 8'h00, 0, got);
      txn(1'b1, 64'h38, 64'h5555AAAA5555AAAA, 8'hF0, 0, got);
      txn(1'b1, 64'h40, 64'h0123456789ABCDEF, 8'h3C, 0, got);
      txn(1'b1, 64'h45, 64'h0, 8'hFF, 0, got);
`ifdef DMEM_STATS_EN
      chk("stats_rd3", 64'(rd_count), 64'd3);
      chk("stats_wr2", 64'(wr_count), 64'd2);
      chk("stats_err1", 64'(err_count), 64'd1);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)
            r_addr = 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(1, 7));
         else if (sel == 1)
            r_addr = (64'(DEPTH) + 64'($urandom_range(0, 100))) * 64'd8;
         else
            r_addr = 64'($urandom_range(0, 15)) * 64'd8;
         txn(1'($urandom_range(0, 1)), r_addr, {$urandom, $urandom},
             8'($urandom_range(0, 255)), $urandom_range(0, 3), got);
      end
      check_stats("random_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
